halflife_ctrl: RTL and testbench

Control stage directly upstream of the 4-bit half-life up/down/load counter. It synchronises and edge-detects raw push-buttons and drives the counter's up/down/load/in strobes. It runs a programmable prescaler that repeatedly reloads the counter with half its current value until it reaches zero. It reads the counter output back as `cnt` and reports busy/done status and the number of halvings performed.

---
 rtl/halflife_ctrl.sv | 145 ++++++++++++++
 tb/tb_halflife_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/halflife_ctrl.sv
// halflife_ctrl: button front-end and decay sequencer for a 4-bit
// up/down/load counter. Buttons are synchronised and edge-detected, then
// decoded into one-cycle up/down/load strobes. A RUN state reloads the
// counter with half its value every max(period,1)+1 cycles until it is zero.
module halflife_ctrl #(
    parameter int N     = 4,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_set,
    input  logic             btn_inc,
    input  logic             btn_dec,
    input  logic             btn_start,
    input  logic [N-1:0]     seed,
    input  logic [DIV_W-1:0] period,
    input  logic [N-1:0]     cnt,
    output logic             up,
    output logic             down,
    output logic             load,
    output logic [N-1:0]     in,
    output logic             busy,
    output logic             done,
    output logic [3:0]       halvings
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Button bit order inside the vectors: 0=set, 1=start, 2=inc, 3=dec
    logic [3:0]       w_btn;
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_prev;
    logic [3:0]       w_pulse;

    logic [1:0]       r_state;
    logic [DIV_W-1:0] r_pre;
    logic             r_up;
    logic             r_down;
    logic             r_load;
    logic [N-1:0]     r_in;
    logic [3:0]       r_halv;

    logic [DIV_W-1:0] w_per;
    logic [N-1:0]     w_half;
    logic [N-1:0]     w_max;

    assign w_btn   = {btn_dec, btn_inc, btn_start, btn_set};
    assign w_pulse = r_sync2 & ~r_prev;

    // A period of 0 is floored to 1 so the counter has always absorbed the
    // previous load before cnt is halved again.
    assign w_per  = (period == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : period;
    assign w_half = cnt >> 1;
    assign w_max  = {N{1'b1}};

    // Two-flop synchroniser followed by a previous-value flop for edge detect
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Sequencer: decodes pulses by priority (set > start > inc > dec) and
    // drives registered strobes; strobes default low so each lasts one cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pre   <= '0;
            r_up    <= 1'b0;
            r_down  <= 1'b0;
            r_load  <= 1'b0;
            r_in    <= '0;
            r_halv  <= '0;
        end else begin
            r_up   <= 1'b0;
            r_down <= 1'b0;
            r_load <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pulse[0]) begin
                        r_load <= 1'b1;
                        r_in   <= seed;
                        r_halv <= '0;
                    end else if (w_pulse[1]) begin
                        if (cnt == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_RUN;
                            r_pre   <= '0;
                            r_halv  <= '0;
                        end
                    end else if (w_pulse[2]) begin
                        // Saturate instead of letting the counter wrap
                        if (cnt != w_max) r_up <= 1'b1;
                    end else if (w_pulse[3]) begin
                        if (cnt != '0) r_down <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_pulse[0]) begin
                        // Abort keeps halvings for inspection until next start
                        r_load  <= 1'b1;
                        r_in    <= seed;
                        r_state <= S_IDLE;
                        r_pre   <= '0;
                    end else if (r_pre == w_per) begin
                        r_pre  <= '0;
                        r_load <= 1'b1;
                        r_in   <= w_half;
                        if (r_halv != 4'hF) r_halv <= r_halv + 4'd1;
                        if (w_half == '0) r_state <= S_DONE;
                    end else begin
                        r_pre <= r_pre + 1'b1;
                    end
                end
                S_DONE: begin
                    if (w_pulse[0]) begin
                        r_load  <= 1'b1;
                        r_in    <= seed;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign up       = r_up;
    assign down     = r_down;
    assign load     = r_load;
    assign in       = r_in;
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign halvings = r_halv;

endmodule

// File: tb/tb_halflife_ctrl.sv
// Bench for halflife_ctrl: a behavioural counter closes the cnt loop, and a
// scoreboard queue holds the strobes each stimulus is expected to produce.
module tb_halflife_ctrl;

    typedef struct {
        logic [2:0] kind;      // {load, up, down}
        logic [3:0] val;       // expected in when kind is load
        int         gap;       // required cycles since previous load, 0 = skip
        bit         want_done; // done must be high alongside this load
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btns = 4'd0;   // 0=set 1=start 2=inc 3=dec
    logic [3:0] seed = 4'd0;
    logic [7:0] period = 8'd0;
    logic [3:0] cnt_m = 4'd0;
    logic       up, down, load, busy, done;
    logic [3:0] in, halvings;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_load = 0;
    bit   both_seen = 1'b0;

    halflife_ctrl #(.N(4), .DIV_W(8)) dut (
        .clk(clk), .rst(rst),
        .btn_set(btns[0]), .btn_inc(btns[2]), .btn_dec(btns[3]), .btn_start(btns[1]),
        .seed(seed), .period(period), .cnt(cnt_m),
        .up(up), .down(down), .load(load), .in(in),
        .busy(busy), .done(done), .halvings(halvings)
    );

    always #5 clk = ~clk;

    // Downstream counter model: load has priority, then up, then down
    always @(posedge clk) begin
        if (load)      cnt_m <= in;
        else if (up)   cnt_m <= cnt_m + 4'd1;
        else if (down) cnt_m <= cnt_m - 4'd1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] k, input logic [3:0] v, input int g, input bit wd);
        exp_t e;
        e.kind = k; e.val = v; e.gap = g; e.want_done = wd;
        q.push_back(e);
    endtask

    task automatic press(input logic [3:0] m);
        @(negedge clk) btns = m;
        repeat (4) @(negedge clk);
        btns = 4'd0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    // Scoreboard: every strobe seen must match the head of the queue
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (busy && done) both_seen = 1'b1;
        if (load || up || down) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", int'({load, up, down}), 0);
            end else begin
                e = q.pop_front();
                chk("strobe_kind", int'({load, up, down}), int'(e.kind));
                if (e.kind == 3'b100) begin
                    chk("load_in", int'(in), int'(e.val));
                    if (e.gap != 0) chk("load_gap", cyc - last_load, e.gap);
                    if (e.want_done) begin
                        chk("done_with_last", int'(done), 1);
                        chk("busy_with_last", int'(busy), 0);
                    end
                end
            end
            if (load) last_load = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_load", int'(load), 0);
        chk("rst_up", int'(up), 0);
        chk("rst_down", int'(down), 0);
        chk("rst_in", int'(in), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_halv", int'(halvings), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: set with seed 12, load appears after the third edge
        seed = 4'd12;
        push(3'b100, 4'd12, 0, 1'b0);
        btns = 4'b0001;
        @(posedge clk);
        @(posedge clk);
        #1 chk("lat_early", int'(load), 0);
        @(posedge clk);
        #1 chk("lat_load", int'(load), 1);
        chk("lat_in", int'(in), 12);
        repeat (3) @(negedge clk);
        btns = 4'd0;
        repeat (4) @(negedge clk);
        wait_drain(10);
        chk("t1_cnt", int'(cnt_m), 12);
        chk("t1_busy", int'(busy), 0);
        chk("t1_done", int'(done), 0);

        // 2: inc saturates at 15, dec ignored at 0
        for (int i = 0; i < 3; i++) begin
            push(3'b010, 4'd0, 0, 1'b0);
            press(4'b0100);
        end
        press(4'b0100);
        wait_drain(10);
        chk("t2_cnt_max", int'(cnt_m), 15);
        seed = 4'd0;
        push(3'b100, 4'd0, 0, 1'b0);
        press(4'b0001);
        press(4'b1000);
        wait_drain(10);
        chk("t2_cnt_zero", int'(cnt_m), 0);

        // 3: seed 12, period 3 -> 6,3,1,0 every 4 cycles
        seed = 4'd12;
        push(3'b100, 4'd12, 0, 1'b0);
        press(4'b0001);
        period = 8'd3;
        push(3'b100, 4'd6, 0, 1'b0);
        push(3'b100, 4'd3, 4, 1'b0);
        push(3'b100, 4'd1, 4, 1'b0);
        push(3'b100, 4'd0, 4, 1'b1);
        press(4'b0010);
        wait_drain(100);
        repeat (2) @(negedge clk);
        chk("t3_done", int'(done), 1);
        chk("t3_busy", int'(busy), 0);
        chk("t3_halv", int'(halvings), 4);
        chk("t3_cnt", int'(cnt_m), 0);

        // 4: period 0 floors to 1 -> loads every 2 cycles
        seed = 4'd8;
        push(3'b100, 4'd8, 0, 1'b0);
        press(4'b0001);
        chk("t4_idle", int'(done), 0);
        period = 8'd0;
        push(3'b100, 4'd4, 0, 1'b0);
        push(3'b100, 4'd2, 2, 1'b0);
        push(3'b100, 4'd1, 2, 1'b0);
        push(3'b100, 4'd0, 2, 1'b1);
        press(4'b0010);
        wait_drain(100);
        repeat (2) @(negedge clk);
        chk("t4_halv", int'(halvings), 4);
        chk("t4_done", int'(done), 1);

        // 5: set + start together mid-run aborts to IDLE
        seed = 4'd12;
        push(3'b100, 4'd12, 0, 1'b0);
        press(4'b0001);
        period = 8'd20;
        push(3'b100, 4'd6, 0, 1'b0);
        press(4'b0010);
        wait_drain(100);
        @(negedge clk);
        chk("t5_cnt6", int'(cnt_m), 6);
        chk("t5_busy_run", int'(busy), 1);
        seed = 4'd9;
        push(3'b100, 4'd9, 0, 1'b0);
        press(4'b0011);
        wait_drain(20);
        repeat (60) @(negedge clk);
        chk("t5_busy", int'(busy), 0);
        chk("t5_done", int'(done), 0);
        chk("t5_halv", int'(halvings), 1);
        chk("t5_cnt", int'(cnt_m), 9);

        // 6: reset during RUN with a halving pending
        seed = 4'd12;
        push(3'b100, 4'd12, 0, 1'b0);
        press(4'b0001);
        period = 8'd6;
        push(3'b100, 4'd6, 0, 1'b0);
        @(negedge clk) btns = 4'b0010;
        repeat (4) @(negedge clk);
        btns = 4'd0;
        wait_drain(100);
        repeat (2) @(negedge clk);
        chk("t6_busy_pre", int'(busy), 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("t6_load", int'(load), 0);
        chk("t6_up", int'(up), 0);
        chk("t6_down", int'(down), 0);
        chk("t6_in", int'(in), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_done", int'(done), 0);
        chk("t6_halv", int'(halvings), 0);
        repeat (30) @(negedge clk);
        chk("t6_quiet", int'(busy), 0);
        seed = 4'd0;
        push(3'b100, 4'd0, 0, 1'b0);
        press(4'b0001);
        press(4'b0010);
        repeat (4) @(negedge clk);
        wait_drain(10);
        chk("t6_zero_done", int'(done), 1);
        chk("t6_zero_busy", int'(busy), 0);
        chk("t6_zero_halv", int'(halvings), 0);

        chk("busy_done_overlap", int'(both_seen), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
